// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared state type and default geometry for the data memory
package data_mem_pkg;
  typedef enum logic {DM_CLEAR, DM_READY} dm_state_e;
  localparam int DM_DW = 8;
  localparam int DM_AW = 8;
endpackage

// File: rtl/data_mem_array.sv
// data_mem_array: unreset DW x 2**AW storage, one sync write port, one registered read port
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int DW = DM_DW,
  parameter int AW = DM_AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/data_mem_sync.sv
// data_mem_sync: valid/ready data memory, 1-cycle registered read, post-reset zero sweep under DATA_MEM_CLEAR_EN
module data_mem_sync
  import data_mem_pkg::*;
#(
  parameter int DW = DM_DW,
  parameter int AW = DM_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          busy
);
  logic          sweep;
  logic [AW-1:0] sweep_addr;
  logic          acc, we, re, rd_seen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata, q;
`ifdef DATA_MEM_CLEAR_EN
  dm_state_e     state;
  logic [AW-1:0] clr_addr;
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= DM_CLEAR;
      clr_addr <= '0;
    end else if (state == DM_CLEAR) begin
      clr_addr <= clr_addr + 1'b1;
      if (&clr_addr) state <= DM_READY;
    end
  end
  assign req_ready  = state == DM_READY;
  assign busy       = state == DM_CLEAR;
  assign sweep      = busy && !reset;
  assign sweep_addr = clr_addr;
`else
  assign req_ready  = 1'b1;
  assign busy       = 1'b0;
  assign sweep      = 1'b0;
  assign sweep_addr = '0;
`endif
  always_comb begin
    acc   = !reset && req_valid && req_ready;
    we    = sweep || (acc && req_we);
    re    = acc && !req_we;
    waddr = sweep ? sweep_addr : req_addr;
    wdata = sweep ? '0 : req_wdata;
  end
  data_mem_array #(.DW(DW), .AW(AW)) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (req_addr),
    .rdata (q)
  );
  // the array read register has no reset, so output reads as zero until the first read after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rd_seen   <= 1'b0;
    end else begin
      rsp_valid <= re;
      if (re) rd_seen <= 1'b1;
    end
  end
  assign rsp_rdata = rd_seen ? q : '0;
endmodule

// File: tb/tb_data_mem_sync.sv
// tb_data_mem_sync: directed and random checks of data_mem_sync against an array reference model
module tb_data_mem_sync;
  localparam int DW = 8, AW = 8, N = 1 << AW;
  localparam int N16 = 1 << 10;
`ifdef DATA_MEM_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic req_ready, rsp_valid, busy;
  logic [DW-1:0] rsp_rdata;
  logic v16 = 1'b0, we16 = 1'b0;
  logic [9:0] a16 = '0;
  logic [15:0] d16 = '0;
  logic rdy16, rv16, busy16;
  logic [15:0] rd16;
  int total = 0, bad = 0;
  logic [DW-1:0] mem [N];
  bit known [N];
  logic exp_valid;
  logic [DW-1:0] exp_data;
  always #5 clk = ~clk;
  data_mem_sync #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy)
  );
  data_mem_sync #(.DW(16), .AW(10)) dut16 (
    .clk(clk), .reset(reset), .req_valid(v16), .req_ready(rdy16), .req_we(we16),
    .req_addr(a16), .req_wdata(d16), .rsp_valid(rv16), .rsp_rdata(rd16), .busy(busy16)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic r, input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    reset = r; req_valid = v; req_we = w; req_addr = a; req_wdata = d;
    @(posedge clk);
    if (r) begin
      exp_valid = 1'b0;
      exp_data = '0;
      if (CLR) for (int i = 0; i < N; i++) begin mem[i] = '0; known[i] = 1'b1; end
    end else if (v && w) begin
      mem[a] = d;
      known[a] = 1'b1;
      exp_valid = 1'b0;
    end else if (v) begin
      exp_valid = 1'b1;
      exp_data = mem[a];
    end else exp_valid = 1'b0;
    #1;
    reset = 1'b0; req_valid = 1'b0;
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_valid});
    chk("rsp_rdata", {24'b0, rsp_rdata}, {24'b0, exp_data});
  endtask
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < N + 8) begin
      chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_len"}, n, CLR ? N : 0);
    chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask
  task automatic step16(input logic w, input logic [9:0] a, input logic [15:0] d, input logic ev, input logic [15:0] ed, input string tag);
    v16 = 1'b1; we16 = w; a16 = a; d16 = d;
    @(posedge clk); #1;
    v16 = 1'b0;
    chk({tag, "_valid"}, {31'b0, rv16}, {31'b0, ev});
    if (ev) chk({tag, "_data"}, {16'b0, rd16}, {16'b0, ed});
  endtask
  initial begin
    logic [AW-1:0] a;
    logic v, w;
    int n;
    for (int i = 0; i < N; i++) known[i] = 1'b0;
    step(1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    wait_ready("sweep");
    if (CLR) for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, AW'(i), '0);
    step(1'b0, 1'b1, 1'b1, 8'h03, 8'hA5);
    step(1'b0, 1'b1, 1'b0, 8'h03, '0);
    chk("a5_direct", {24'b0, rsp_rdata}, 32'hA5);
    step(1'b0, 1'b1, 1'b1, 8'h10, 8'h01);
    step(1'b0, 1'b1, 1'b1, 8'h11, 8'h02);
    step(1'b0, 1'b1, 1'b1, 8'h12, 8'h03);
    step(1'b0, 1'b1, 1'b0, 8'h10, '0);
    step(1'b0, 1'b1, 1'b0, 8'h11, '0);
    step(1'b0, 1'b1, 1'b0, 8'h12, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    chk("stream_hold", {24'b0, rsp_rdata}, 32'h03);
    step(1'b0, 1'b1, 1'b1, 8'hFF, 8'h5C);
    step(1'b0, 1'b1, 1'b1, 8'h00, 8'h3E);
    step(1'b0, 1'b1, 1'b0, 8'hFF, '0);
    step(1'b0, 1'b1, 1'b0, 8'h00, '0);
    step(1'b0, 1'b1, 1'b1, 8'h20, 8'h11);
    step(1'b0, 1'b1, 1'b0, 8'h20, '0);
    step(1'b1, 1'b1, 1'b1, 8'h20, 8'hFF);
    wait_ready("rst_wr");
    step(1'b0, 1'b1, 1'b0, 8'h20, '0);
    chk("rst_wr_data", {24'b0, rsp_rdata}, CLR ? 32'h00 : 32'h11);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    wait_ready("mid_rst");
    for (int i = 0; i < 400; i++) begin
      a = AW'($urandom);
      v = $urandom_range(0, 3) != 0;
      w = $urandom_range(0, 1) == 1 || !known[a];
      step(1'b0, v, w, a, DW'($urandom));
    end
    n = 0;
    while (!rdy16 && n < N16 + 8) begin @(posedge clk); #1; n++; end
    chk("w16_ready", {31'b0, rdy16}, 32'd1);
    chk("w16_busy", {31'b0, busy16}, 32'd0);
    step16(1'b1, 10'h3FF, 16'hBEEF, 1'b0, '0, "w16_wr_top");
    step16(1'b0, 10'h3FF, '0, 1'b1, 16'hBEEF, "w16_rd_top");
    step16(1'b1, 10'h000, 16'h1234, 1'b0, '0, "w16_wr_zero");
    step16(1'b0, 10'h3FF, '0, 1'b1, 16'hBEEF, "w16_rd_top2");
    step16(1'b0, 10'h000, '0, 1'b1, 16'h1234, "w16_rd_zero");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
